// File: rtl/hazard_int_ctrl_if.sv
// Signal bundle between the decode/execute pipeline and its hazard/interrupt sequencer.
// The pipeline side is the master; the sequencer is the slave.
`timescale 1ns/1ps

interface hazard_int_ctrl_if;
    // Pipeline status seen by the sequencer
    logic [2:0] id_rs;
    logic [2:0] id_rd;
    logic       id_uses_rs;
    logic       id_uses_rd;
    logic [2:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_branch_tk;
    logic       int_req;

    // Sequencer controls back to the pipeline
    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic [1:0] push_sel;
    logic       vec_load;
    logic       int_ack;
    logic       busy;

    modport master (
        output id_rs, id_rd, id_uses_rs, id_uses_rd, ex_rd, ex_mem_read,
               ex_branch_tk, int_req,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, push_sel,
               vec_load, int_ack, busy
    );

    modport slave (
        input  id_rs, id_rd, id_uses_rs, id_uses_rd, ex_rd, ex_mem_read,
               ex_branch_tk, int_req,
        output pc_stall, if_id_stall, if_id_flush, id_ex_flush, push_sel,
               vec_load, int_ack, busy
    );
endinterface

// File: rtl/hazard_int_ctrl.sv
// Decode/execute boundary sequencer: load-use stalls, taken-branch flushes and the
// interrupt entry sequence (drain, push PC low/high halves, load vector).
`timescale 1ns/1ps

module hazard_int_ctrl #(
    parameter int LOAD_STALL   = 1,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_int_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        PUSH_LO = 3'd2,
        PUSH_HI = 3'd3,
        VECTOR  = 3'd4
    } state_t;

    localparam logic [1:0] PUSH_NONE = 2'b00;
    localparam logic [1:0] PUSH_LOW  = 2'b01;
    localparam logic [1:0] PUSH_HIGH = 2'b10;

    // cnt holds the stall cycles still owed after the current one, so the hazard
    // cycle itself is the first of LOAD_STALL stall cycles.
    localparam logic [1:0] CNT_LOAD  = 2'(LOAD_STALL - 1);
    localparam logic [2:0] DCNT_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic [2:0] dcnt_q;
    logic [2:0] dcnt_d;
    logic       live_q;
    logic       live;
    logic       hz;
    logic       rs_hit;
    logic       rd_hit;

    logic       pc_stall_c;
    logic       if_id_stall_c;
    logic       if_id_flush_c;
    logic       id_ex_flush_c;
    logic [1:0] push_sel_c;
    logic       vec_load_c;
    logic       int_ack_c;
    logic       busy_c;

    assign rs_hit = bus.id_uses_rs && (bus.id_rs == bus.ex_rd);
    assign rd_hit = bus.id_uses_rd && (bus.id_rd == bus.ex_rd);
    assign hz     = bus.ex_mem_read && (rs_hit || rd_hit);

    // Outputs stay quiet while reset is held and for the first cycle after release.
    assign live = rst_n && live_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            dcnt_q  <= 3'd0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dcnt_d        = dcnt_q;
        pc_stall_c    = 1'b0;
        if_id_stall_c = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        push_sel_c    = PUSH_NONE;
        vec_load_c    = 1'b0;
        int_ack_c     = 1'b0;
        busy_c        = 1'b0;

        if (live) begin
            busy_c = (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (bus.ex_branch_tk) begin
                        // Wrong-path instructions are squashed; any pending stall is moot.
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                        cnt_d         = 2'd0;
                    end else if (bus.int_req && (cnt_q == 2'd0)) begin
                        state_d       = DRAIN;
                        dcnt_d        = DCNT_LOAD;
                        pc_stall_c    = hz;
                        if_id_stall_c = hz;
                        id_ex_flush_c = hz;
                    end else begin
                        if (hz || (cnt_q != 2'd0)) begin
                            pc_stall_c    = 1'b1;
                            if_id_stall_c = 1'b1;
                            id_ex_flush_c = 1'b1;
                        end
                        if (cnt_q != 2'd0) begin
                            cnt_d = cnt_q - 2'd1;
                        end else if (hz) begin
                            cnt_d = CNT_LOAD;
                        end
                    end
                end
                DRAIN: begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    if (dcnt_q == 3'd0) begin
                        state_d = PUSH_LO;
                    end else begin
                        dcnt_d = dcnt_q - 3'd1;
                    end
                end
                PUSH_LO: begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    push_sel_c    = PUSH_LOW;
                    state_d       = PUSH_HI;
                end
                PUSH_HI: begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    push_sel_c    = PUSH_HIGH;
                    state_d       = VECTOR;
                end
                VECTOR: begin
                    vec_load_c    = 1'b1;
                    if_id_flush_c = 1'b1;
                    int_ack_c     = 1'b1;
                    state_d       = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.pc_stall    = pc_stall_c;
    assign bus.if_id_stall = if_id_stall_c;
    assign bus.if_id_flush = if_id_flush_c;
    assign bus.id_ex_flush = id_ex_flush_c;
    assign bus.push_sel    = push_sel_c;
    assign bus.vec_load    = vec_load_c;
    assign bus.int_ack     = int_ack_c;
    assign bus.busy        = busy_c;

endmodule
